imem_uart_loader: RTL and testbench



---
 rtl/imem_uart_loader_if.sv | 11 +
 rtl/imem_uart_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_uart_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port: the loader drives it (master), the imem consumes it (slave).
interface imem_uart_loader_if #(
   parameter int unsigned ADDR_WIDTH = 16
);
   logic                  imem_wr;
   logic [ADDR_WIDTH-3:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (output imem_wr, output imem_addr, output imem_wdata);
   modport slave  (input imem_wr, input imem_addr, input imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART (8N1) program-image receiver that packs bytes little-endian into 32-bit imem words
// and holds the CPU in reset while a load is in progress.
module imem_uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned ADDR_WIDTH   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load_imem,
   input  logic                      uart0_rxd,
   imem_uart_loader_if.master        imem,
   output logic                      cpu_hold,
   output logic                      load_busy,
   output logic [ADDR_WIDTH-3:0]     word_count,
   output logic                      frame_err
);
   localparam int unsigned WordAw = ADDR_WIDTH - 2;
   localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

   logic              rxd_meta_q, rxd_meta_d, rxd_s_q, rxd_s_d;
   logic              load_meta_q, load_meta_d, load_s_q, load_s_d, load_prev_q, load_prev_d;
   rx_state_e         state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              byte_valid_q, byte_valid_d;
   logic [7:0]        byte_q, byte_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       word_q, word_d;
   logic              imem_wr_q, imem_wr_d;
   logic [WordAw-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic [WordAw-1:0] word_count_q, word_count_d;
   logic              frame_err_q, frame_err_d;
   logic              cpu_hold_q, cpu_hold_d;

   always_comb begin
      rxd_meta_d   = uart0_rxd;
      rxd_s_d      = rxd_meta_q;
      load_meta_d  = load_imem;
      load_s_d     = load_meta_q;
      load_prev_d  = load_s_q;
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      byte_d       = byte_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      imem_wr_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      word_count_d = word_count_q;
      frame_err_d  = frame_err_q;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rxd_s_q) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rxd_s_q ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d     = '0;
               shift_d   = {rxd_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (cnt_q == BitLast) begin
               state_d = StIdle;
               if (rxd_s_q) begin
                  byte_valid_d = 1'b1;
                  byte_d       = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Load low aborts any frame silently, including one completing this cycle.
      if (!load_s_q) begin
         state_d      = StIdle;
         byte_valid_d = 1'b0;
         frame_err_d  = frame_err_q;
      end

      if (byte_valid_q) begin
         byte_idx_d = byte_idx_q + 1'b1;
         unique case (byte_idx_q)
            2'd0: word_d[7:0]   = byte_q;
            2'd1: word_d[15:8]  = byte_q;
            2'd2: word_d[23:16] = byte_q;
            2'd3: begin
               imem_wr_d    = 1'b1;
               imem_addr_d  = word_count_q;
               imem_wdata_d = {byte_q, word_q};
               word_count_d = word_count_q + 1'b1;
            end
            default: ;
         endcase
      end

      if (load_s_q && !load_prev_q) begin
         word_count_d = '0;
         byte_idx_d   = '0;
         word_d       = '0;
         frame_err_d  = 1'b0;
      end

      cpu_hold_d = load_s_q | imem_wr_d | imem_wr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_q   <= 1'b1;
         rxd_s_q      <= 1'b1;
         load_meta_q  <= 1'b0;
         load_s_q     <= 1'b0;
         load_prev_q  <= 1'b0;
         state_q      <= StIdle;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         byte_q       <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         imem_wr_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         word_count_q <= '0;
         frame_err_q  <= 1'b0;
         cpu_hold_q   <= 1'b0;
      end else begin
         rxd_meta_q   <= rxd_meta_d;
         rxd_s_q      <= rxd_s_d;
         load_meta_q  <= load_meta_d;
         load_s_q     <= load_s_d;
         load_prev_q  <= load_prev_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         byte_q       <= byte_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         imem_wr_q    <= imem_wr_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         word_count_q <= word_count_d;
         frame_err_q  <= frame_err_d;
         cpu_hold_q   <= cpu_hold_d;
      end
   end

   assign imem.imem_wr    = imem_wr_q;
   assign imem.imem_addr  = imem_addr_q;
   assign imem.imem_wdata = imem_wdata_q;
   assign cpu_hold        = cpu_hold_q;
   assign load_busy       = (state_q != StIdle) | imem_wr_q;
   assign word_count      = word_count_q;
   assign frame_err       = frame_err_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: drives UART frames and compares imem writes with a byte-list model.
module tb_imem_uart_loader;
   localparam int unsigned C   = 16;
   localparam int unsigned AW  = 8;
   localparam int unsigned WAW = AW - 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           load_imem = 1'b0;
   logic           uart0_rxd = 1'b1;
   logic           cpu_hold, load_busy, frame_err;
   logic [WAW-1:0] word_count;

   imem_uart_loader_if #(.ADDR_WIDTH(AW)) imem ();

   imem_uart_loader #(.CLKS_PER_BIT(C), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_imem  (load_imem),
      .uart0_rxd  (uart0_rxd),
      .imem       (imem),
      .cpu_hold   (cpu_hold),
      .load_busy  (load_busy),
      .word_count (word_count),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] obs_q[$];
   logic [63:0] exp_q[$];
   logic [7:0]  m_bytes[$];
   int          m_ptr = 0;
   logic        wr_prev = 1'b0;
   logic        hold_watch = 1'b0;
   int          hold_drops = 0;
   logic [63:0] mon_rec;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Every write is recorded, and a strobe must never last two cycles.
   always @(negedge clk) begin
      if (imem.imem_wr === 1'b1) begin
         mon_rec = '0;
         mon_rec[31:0] = imem.imem_wdata;
         mon_rec[32 +: WAW] = imem.imem_addr;
         obs_q.push_back(mon_rec);
         checks++;
         assert (wr_prev == 1'b0) else begin
            errors++;
            $error("FAIL wr_pulse_width: observed 2+ cycles expected 1 cycle");
         end
      end
      wr_prev = (imem.imem_wr === 1'b1);
      if (hold_watch && cpu_hold !== 1'b1) hold_drops++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_start();
      m_bytes.delete();
      m_ptr = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [63:0] e;
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
         e = '0;
         e[31:0] = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
         e[32 +: WAW] = WAW'(m_ptr);
         exp_q.push_back(e);
         m_ptr = (m_ptr + 1) % (1 << WAW);
         m_bytes.delete();
      end
   endtask

   task automatic line_byte(input logic [7:0] b, input logic stop_bit);
      uart0_rxd = 1'b0;
      cyc(C);
      for (int i = 0; i < 8; i++) begin
         uart0_rxd = b[i];
         cyc(C);
      end
      uart0_rxd = stop_bit;
      cyc(C);
      uart0_rxd = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      line_byte(b, 1'b1);
      model_byte(b);
   endtask

   task automatic check_writes(input string tag);
      int n;
      chk($sformatf("%s_nwrites", tag), 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic new_load();
      hold_watch = 1'b0;
      load_imem = 1'b0;
      cyc(6);
      load_imem = 1'b1;
      model_start();
      cyc(4);
   endtask

   initial begin
      logic [7:0] basic [8];
      basic = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};

      // Reset values
      cyc(4);
      chk("rst_wr", 64'(imem.imem_wr), 64'd0);
      chk("rst_addr", 64'(imem.imem_addr), 64'd0);
      chk("rst_wdata", 64'(imem.imem_wdata), 64'd0);
      chk("rst_count", 64'(word_count), 64'd0);
      chk("rst_ferr", 64'(frame_err), 64'd0);
      chk("rst_busy", 64'(load_busy), 64'd0);
      chk("rst_hold", 64'(cpu_hold), 64'd0);
      reset = 1'b0;
      cyc(2);

      // Basic load
      new_load();
      chk("basic_hold", 64'(cpu_hold), 64'd1);
      hold_watch = 1'b1;
      for (int i = 0; i < 8; i++) send(basic[i]);
      cyc(2 * C);
      check_writes("basic");
      chk("basic_count", 64'(word_count), 64'd2);
      chk("basic_ferr", 64'(frame_err), 64'd0);

      // Glitch rejection: short low pulse must not become a byte
      uart0_rxd = 1'b0;
      cyc(4);
      uart0_rxd = 1'b1;
      cyc(3);
      chk("glitch_busy_start", 64'(load_busy), 64'd1);
      cyc(2 * C);
      chk("glitch_busy_end", 64'(load_busy), 64'd0);
      chk("glitch_ferr", 64'(frame_err), 64'd0);
      chk("glitch_count", 64'(word_count), 64'd2);
      check_writes("glitch");

      // Framing error, then four good bytes
      new_load();
      hold_watch = 1'b1;
      line_byte(8'hAA, 1'b0);
      cyc(2 * C);
      chk("ferr_set", 64'(frame_err), 64'd1);
      for (int i = 1; i <= 4; i++) send(8'(i));
      cyc(2 * C);
      check_writes("ferr");
      chk("ferr_sticky", 64'(frame_err), 64'd1);
      chk("ferr_count", 64'(word_count), 64'd1);

      // Partial word discard
      new_load();
      chk("part_ferr_clr", 64'(frame_err), 64'd0);
      chk("part_count_clr", 64'(word_count), 64'd0);
      for (int i = 0; i < 3; i++) send(8'($urandom));
      cyc(2 * C);
      load_imem = 1'b0;
      cyc(2);
      chk("part_hold_2", 64'(cpu_hold), 64'd1);
      cyc(1);
      chk("part_hold_3", 64'(cpu_hold), 64'd0);
      cyc(C);
      exp_q.delete();
      check_writes("part_discard");
      load_imem = 1'b1;
      model_start();
      cyc(4);
      chk("part_new_count", 64'(word_count), 64'd0);
      for (int i = 0; i < 4; i++) send(8'($urandom));
      cyc(2 * C);
      check_writes("part_new");

      // Pointer wrap
      new_load();
      hold_watch = 1'b1;
      for (int i = 0; i < 4 * 64 + 4; i++) send(8'($urandom));
      cyc(2 * C);
      check_writes("wrap");
      chk("wrap_count", 64'(word_count), 64'd1);
      chk("hold_throughout", 64'(hold_drops), 64'd0);

      // Reset during DATA of the 4th byte
      new_load();
      for (int i = 0; i < 3; i++) send(8'($urandom));
      fork
         line_byte(8'hFF, 1'b1);
         begin
            cyc(3 * C);
            reset = 1'b1;
            cyc(1);
            chk("rstmid_busy", 64'(load_busy), 64'd0);
            chk("rstmid_wr", 64'(imem.imem_wr), 64'd0);
            chk("rstmid_hold", 64'(cpu_hold), 64'd0);
            cyc(2);
            reset = 1'b0;
         end
      join
      model_start();
      exp_q.delete();
      cyc(2 * C);
      check_writes("rstmid_none");
      for (int i = 0; i < 4; i++) send(8'($urandom));
      cyc(2 * C);
      check_writes("rstmid_after");
      chk("rstmid_count", 64'(word_count), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
